// File: rtl/uart_pkg.sv
// Shared definitions for the UART baud generator.
//   state_t  : frame-tracking states (IDLE, RUN, DRAIN)
//   MIN_DIV  : smallest legal bit period for the default oversample ratio
//   min_div  : smallest legal bit period for a given oversample ratio
//   def_div  : reset bit period in clock cycles, CLK_HZ/BAUD (integer)
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int OSR_DEF = 16;
  localparam int MIN_DIV = 2 * OSR_DEF;

  function automatic int min_div(input int osr);
    return 2 * osr;
  endfunction

  function automatic int def_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tick_cnt.sv
// Modulo-N counter with synchronous clear and a wrap pulse.
//   clk_in  : clock, rising edge
//   rst     : synchronous active-high reset (count -> 0)
//   clr     : force the next count to 0 (has priority over en)
//   en      : advance the count
//   n       : modulus; the count runs 0..n-1
//   cnt_nxt : value the count takes at the next edge (combinational)
//   wrap    : high in the cycle the count advances from n-1 back to 0
// The next value is exported so the parent can register its outputs in the
// same cycle the count changes.
module uart_tick_cnt #(
  parameter int W = 25
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] n,
  output logic [W-1:0] cnt_nxt,
  output logic         wrap
);

  logic [W-1:0] cnt;
  logic         last;

  assign last = (cnt == n - W'(1));

  always_comb begin
    cnt_nxt = cnt;
    wrap    = 1'b0;
    if (clr) begin
      cnt_nxt = '0;
    end else if (en) begin
      if (last) begin
        cnt_nxt = '0;
        wrap    = 1'b1;
      end else begin
        cnt_nxt = cnt + W'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_nxt;
  end

endmodule

// File: rtl/uart_baud_gen.sv
// UART baud generator with frame tracking.
//   clk_in   : system clock, rising edge
//   rst      : synchronous active-high reset
//   sense    : serial line (idle high); low starts a frame
//   bsy      : controller busy; low-then-high marks end of frame
//   div_in   : bit period in clk_in cycles, taken on div_load in IDLE only
//   div_load : one-cycle load request
//   clk_out  : high during the first half of each bit
//   bit_tick : pulse at the start of each bit (RUN only)
//   mid_tick : pulse at the mid-point of each bit
//   os_tick  : OSR pulses per bit
//   active   : state is RUN or DRAIN
//   div_cur  : divisor in effect
// Handshake: none; every input is sampled on each rising edge and every
// output is a flop loaded from next-state values, so outputs line up with the
// state/counter registers and no input reaches an output combinationally.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 9600,
  parameter int OSR    = 16,
  parameter int DIV_W  = 25
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sense,
  input  logic             bsy,
  input  logic [DIV_W-1:0] div_in,
  input  logic             div_load,
  output logic             clk_out,
  output logic             bit_tick,
  output logic             mid_tick,
  output logic             os_tick,
  output logic             active,
  output logic [DIV_W-1:0] div_cur
);

  localparam int               OS_SH    = $clog2(OSR);
  localparam int               KW       = OS_SH + 1;
  localparam logic [DIV_W-1:0] DEF_DIV  = DIV_W'(def_div(CLK_HZ, BAUD));
  localparam logic [DIV_W-1:0] MIN_D    = DIV_W'(min_div(OSR));
  localparam logic [DIV_W-1:0] DEF_HALF = DEF_DIV >> 1;
  localparam logic [DIV_W-1:0] DEF_Q    = DEF_DIV >> OS_SH;

  state_t           state, state_nxt;
  logic             arm, arm_nxt;
  logic             eof;
  logic [DIV_W-1:0] div_r, half_r, q_r;
  logic [DIV_W-1:0] ld_div;
  logic [DIV_W-1:0] bcnt_nxt, os_nxt;
  logic             bcnt_wrap, os_wrap_raw, os_wrap;
  logic             bcnt_clr, os_clr;
  logic [KW-1:0]    k, k_nxt;
  logic             active_nxt;

  // ---------------- FSM next state ----------------
  assign eof = arm && bsy;

  always_comb begin
    state_nxt = state;
    arm_nxt   = arm;
    case (state)
      IDLE: begin
        arm_nxt = 1'b0;
        if (!sense) state_nxt = RUN;
      end
      RUN: begin
        if (eof) begin
          arm_nxt = 1'b0;
          // A new start bit in the same cycle keeps the frame running.
          if (sense) state_nxt = DRAIN;
        end else if (!bsy) begin
          arm_nxt = 1'b1;
        end
      end
      DRAIN: begin
        arm_nxt = 1'b0;
        if (bcnt_wrap) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        arm_nxt   = 1'b0;
      end
    endcase
  end

  assign active_nxt = (state_nxt != IDLE);

  // ---------------- counters ----------------
  // bcnt sits at 0 through IDLE, so the first active cycle is bit position 0.
  assign bcnt_clr = (state == IDLE);

  uart_tick_cnt #(.W(DIV_W)) u_bcnt (
    .clk_in  (clk_in),
    .rst     (rst),
    .clr     (bcnt_clr),
    .en      (1'b1),
    .n       (div_r),
    .cnt_nxt (bcnt_nxt),
    .wrap    (bcnt_wrap)
  );

  // The sub-counter restarts with every bit, so the remainder of div_r/OSR
  // is swallowed at the end of the bit rather than drifting into the next.
  assign os_clr = (bcnt_nxt == '0);

  uart_tick_cnt #(.W(DIV_W)) u_oscnt (
    .clk_in  (clk_in),
    .rst     (rst),
    .clr     (os_clr),
    .en      (1'b1),
    .n       (q_r),
    .cnt_nxt (os_nxt),
    .wrap    (os_wrap_raw)
  );

  assign os_wrap = os_wrap_raw && !os_clr;

  // k counts sub-periods completed in this bit; ticks stop once OSR are out.
  always_comb begin
    k_nxt = k;
    if (os_clr)       k_nxt = '0;
    else if (os_wrap) k_nxt = k + KW'(1);
  end

  // ---------------- divisor load ----------------
  assign ld_div = (div_in < MIN_D) ? MIN_D : div_in;

  // ---------------- registers ----------------
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state    <= IDLE;
      arm      <= 1'b0;
      k        <= '0;
      div_r    <= DEF_DIV;
      half_r   <= DEF_HALF;
      q_r      <= DEF_Q;
      clk_out  <= 1'b0;
      bit_tick <= 1'b0;
      mid_tick <= 1'b0;
      os_tick  <= 1'b0;
      active   <= 1'b0;
    end else begin
      state <= state_nxt;
      arm   <= arm_nxt;
      k     <= k_nxt;
      if (div_load && (state == IDLE)) begin
        div_r  <= ld_div;
        half_r <= ld_div >> 1;
        q_r    <= ld_div >> OS_SH;
      end
      clk_out  <= active_nxt && (bcnt_nxt < half_r);
      bit_tick <= (state_nxt == RUN) && (bcnt_nxt == '0);
      mid_tick <= active_nxt && (bcnt_nxt == half_r);
      os_tick  <= active_nxt && (os_nxt == '0) && (k_nxt < KW'(OSR));
      active   <= active_nxt;
    end
  end

  assign div_cur = div_r;

endmodule

// File: doc/uart_baud_gen.md
UART_BAUD_GEN -- requirements
Module: uart_baud_gen

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, meaning the clk_in frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, meaning the reset baud rate.
REQ-003 SHALL have parameter OSR, default 16, meaning oversample ticks per bit (power of two, 4..16).
REQ-004 SHALL have parameter DIV_W, default 25, meaning the width of the divisor and counters.
REQ-005 SHALL have port clk_in  input  1  single system clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port sense  input  1  serial line, idle high; low means start of frame.
REQ-008 SHALL have port bsy  input  1  from uart_controller; a low-then-high sequence marks end of frame.
REQ-009 SHALL have port div_in  input  DIV_W  runtime bit period, in clk_in cycles.
REQ-010 SHALL have port div_load  input  1  one-cycle request to load div_in.
REQ-011 SHALL have port clk_out  output  1  baud square wave, high during the first half of each bit.
REQ-012 SHALL have port bit_tick  output  1  one-cycle pulse at the start of each bit period.
REQ-013 SHALL have port mid_tick  output  1  one-cycle pulse at the mid-point of each bit period.
REQ-014 SHALL have port os_tick  output  1  OSR pulses per bit period.
REQ-015 SHALL have port active  output  1  high while the state is RUN or DRAIN.
REQ-016 SHALL have port div_cur  output  DIV_W  divisor currently in effect.

Function
REQ-017 SHALL hold divisor register div_r, with reset value DEF_DIV = CLK_HZ/BAUD (integer).
REQ-018 SHALL load div_r from div_in on div_load only in IDLE; div_load in RUN/DRAIN is ignored.
REQ-019 SHALL clamp loaded values below MIN_DIV = 2*OSR to MIN_DIV.
REQ-020 SHALL implement the states IDLE, RUN and DRAIN with these transitions:
- IDLE->RUN on sense==0.
- RUN->DRAIN on the end-of-frame event.
- DRAIN->IDLE at bit-counter wrap.
REQ-021 SHALL arm end-of-frame when bsy==0 is sampled in RUN; the end-of-frame event is bsy==1 while armed, and the arm clears on the event.
REQ-022 SHALL give sense==0 precedence over a same-cycle end-of-frame: the state stays RUN, the arm clears and the counters continue.
REQ-023 SHALL, in RUN/DRAIN, count bit counter bcnt 0..div_r-1 and wrap to 0.
REQ-024 SHALL hold bcnt at 0 in IDLE.
REQ-025 SHALL pulse bit_tick when bcnt==0 in RUN; bit_tick and clk_out SHALL be high in the first active cycle.
REQ-026 SHALL pulse mid_tick when bcnt==div_r>>1, in RUN or DRAIN.
REQ-027 SHALL drive clk_out=1 for bcnt < div_r>>1 and 0 otherwise while active, and 0 in IDLE.
REQ-028 SHALL generate os_tick as follows:
- Sub-period q = div_r/OSR (floor).
- os_tick pulses at bcnt == k*q for k = 0..OSR-1.
- The remainder cycles are absorbed after the last tick.
- No os_tick occurs in IDLE.
REQ-029 SHALL, in DRAIN, emit no bit_tick and return to IDLE in the cycle after bcnt==div_r-1.
REQ-030 SHALL keep all outputs registered, with no combinational path from input to output.
REQ-031 SHALL compute arithmetic in DIV_W bits; div_r>>1 and q SHALL be computed once per load, not per cycle.

Reset
REQ-032 SHALL, on rst=1, set the following, regardless of state or mid-bit position:
- state=IDLE, div_r=DEF_DIV, bcnt=0, arm=0.
- clk_out=0, bit_tick=0, mid_tick=0, os_tick=0, active=0.
- div_cur=DEF_DIV.
REQ-033 SHALL give rst priority over sense, bsy and div_load in the same cycle.

Structure
REQ-034 SHALL place the state enum, MIN_DIV and a def_div(CLK_HZ, BAUD) function in shared package uart_pkg.
REQ-035 SHALL use one sub-module, uart_tick_cnt: a modulo-N counter with wrap pulse, instantiated for bcnt and for the oversample sub-counter.

Verification (CLK_HZ=50000000, BAUD=9600, OSR=16)
REQ-036 SHALL cover: release rst, sense low -> active=1 and bit_tick=1, clk_out=1 in the first active cycle; next bit_tick 5208 cycles later; mid_tick at bcnt 2604; 16 os_tick spaced 325 cycles.
REQ-037 SHALL cover: div_in=20 with div_load in IDLE -> div_cur=32 (clamped); bit period 32 cycles, os_tick every 2, clk_out high 16 / low 16.
REQ-038 SHALL cover: div_load=1 with div_in=100 while RUN -> div_cur unchanged, period unchanged.
REQ-039 SHALL cover: bsy low then high at bcnt 10 (div 32) -> DRAIN; no further bit_tick; active falls in the cycle after bcnt 31; clk_out=0 in IDLE.
REQ-040 SHALL cover: sense low in the same cycle as the armed bsy rise -> state remains RUN, bit_tick cadence unbroken.
REQ-041 SHALL cover: rst asserted at bcnt 17 in RUN -> next cycle all outputs 0, div_cur=5208, state IDLE.
